// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight bursting requesters sharing one word path.
// Grants whole bursts, muxes the owner's data to a valid/ready sink, and
// force-releases an owner that stops requesting for TIMEOUT cycles.
module mux8_rr_arbiter #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 16,
   parameter int CW      = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [7:0]      i_req,
   input  logic [7:0]      i_last,
   input  logic [8*DW-1:0] i_data,
   input  logic            i_ready,
   output logic [7:0]      o_gnt,
   output logic [2:0]      o_sel,
   output logic            o_valid,
   output logic [DW-1:0]   o_data,
   output logic [CW-1:0]   o_beat_cnt,
   output logic            o_timeout
);
   localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [7:0]    gnt_q, gnt_d;
   logic [2:0]    sel_q, sel_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          tout_q, tout_d;

   logic [DW-1:0] words [8];
   logic          win_found;
   logic [2:0]    win_idx;
   logic [2:0]    cand;
   logic          accept;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         words[k] = i_data[k*DW +: DW];
      end
   end

   assign o_valid    = (state_q == BUSY) && i_req[sel_q];
   assign o_data     = o_valid ? words[sel_q] : '0;
   assign accept     = o_valid && i_ready;
   assign o_gnt      = gnt_q;
   assign o_sel      = sel_q;
   assign o_beat_cnt = cnt_q;
   assign o_timeout  = tout_q;

   // Search starts just past the last owner, so it becomes lowest priority
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= 8; k++) begin
         cand = ptr_q + 3'(k);
         if (!win_found && i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      tout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            idle_d = '0;
            if (win_found) begin
               state_d = BUSY;
               sel_d   = win_idx;
               gnt_d   = 8'h01 << win_idx;
            end
         end
         BUSY: begin
            if (accept && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (i_req[sel_q]) begin
               idle_d = '0;
            end else if (idle_q != IDLE_MAX) begin
               idle_d = idle_q + 1'b1;
            end
            // A completing last beat wins over a timeout that expires in the same cycle
            if (accept && i_last[sel_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = sel_q;
               cnt_d   = '0;
               idle_d  = '0;
            end else if ((TIMEOUT > 0) && (idle_q == IDLE_MAX)) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = sel_q;
               cnt_d   = '0;
               idle_d  = '0;
               tout_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // o_sel keeps the last owner through IDLE so the mux select only moves on a new grant
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= 3'd7;
         cnt_q   <= '0;
         idle_q  <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         tout_q  <= tout_d;
      end
   end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Testbench for mux8_rr_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mux8_rr_arbiter;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;
   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b1;
   logic [7:0]      req      = '0;
   logic [7:0]      last     = '0;
   logic            ready    = 1'b0;
   logic [8*DW-1:0] data_bus = '0;
   logic [7:0]      gnt;
   logic [2:0]      sel;
   logic            valid;
   logic [DW-1:0]   data;
   logic [CW-1:0]   beat_cnt;
   logic            timeout;

   int n_checks = 0;
   int n_pass   = 0;

   mux8_rr_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_last     (last),
      .i_data     (data_bus),
      .i_ready    (ready),
      .o_gnt      (gnt),
      .o_sel      (sel),
      .o_valid    (valid),
      .o_data     (data),
      .o_beat_cnt (beat_cnt),
      .o_timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] l, input logic rdy);
      req   = r;
      last  = l;
      ready = rdy;
   endtask

   task automatic setWord(input int k, input logic [DW-1:0] v);
      data_bus[k*DW +: DW] = v;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: owner index (-1 when idle), last owner, burst bookkeeping
   int m_owner = -1;
   int m_ptr   = 7;
   int m_sel   = 0;
   int m_beats = 0;
   int m_idle  = 0;
   bit m_tout  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_ptr   = 7;
         m_sel   = 0;
         m_beats = 0;
         m_idle  = 0;
         m_tout  = 1'b0;
      end else if (m_owner < 0) begin
         m_tout = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            int c;
            c = (m_ptr + k) % 8;
            if (m_owner < 0 && req[c]) begin
               m_owner = c;
               m_sel   = c;
               m_beats = 0;
               m_idle  = 0;
            end
         end
      end else begin
         bit acc;
         acc = req[m_owner] && ready;
         if (acc && last[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
            m_beats = 0;
            m_idle  = 0;
            m_tout  = 1'b0;
         end else if (TIMEOUT > 0 && m_idle >= TIMEOUT) begin
            m_ptr   = m_owner;
            m_owner = -1;
            m_beats = 0;
            m_idle  = 0;
            m_tout  = 1'b1;
         end else begin
            m_tout = 1'b0;
            if (acc && m_beats < CNT_MAX) m_beats++;
            if (req[m_owner]) m_idle = 0;
            else m_idle++;
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0]    eg;
      logic          ev;
      logic [DW-1:0] ed;
      eg = '0;
      ev = 1'b0;
      ed = '0;
      if (m_owner >= 0) begin
         eg = 8'h01 << m_owner;
         ev = req[m_owner];
         if (ev) ed = data_bus[m_owner*DW +: DW];
      end
      checkOutput("model_gnt", 64'(gnt), 64'(eg));
      checkOutput("model_sel", 64'(sel), 64'(m_sel));
      checkOutput("model_valid", 64'(valid), 64'(ev));
      checkOutput("model_data", 64'(data), 64'(ed));
      checkOutput("model_beat_cnt", 64'(beat_cnt), 64'(m_beats));
      checkOutput("model_timeout", 64'(timeout), 64'(m_tout));
   end

   logic [7:0]    rr_seq [8] = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00};
   logic [DW-1:0] burst   [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
   logic [7:0]    sticky = '0;

   initial begin
      int b;
      #1 rst_n = 1'b0;
      applyStimulus(8'h00, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         nextCycle();
         checkOutput("idle_gnt", 64'(gnt), 64'h0);
         checkOutput("idle_valid", 64'(valid), 64'h0);
         checkOutput("idle_sel", 64'(sel), 64'h0);
         checkOutput("idle_timeout", 64'(timeout), 64'h0);
      end

      // Requesters 0 and 7 with single-beat bursts alternate, one bubble between grants
      setWord(0, 32'hA000_0000);
      setWord(7, 32'hB777_7777);
      applyStimulus(8'h81, 8'h81, 1'b1);
      for (int i = 0; i < 8; i++) begin
         nextCycle();
         checkOutput("rr_gnt", 64'(gnt), 64'(rr_seq[i]));
         if (rr_seq[i] == 8'h01) checkOutput("rr_data0", 64'(data), 64'hA000_0000);
         else if (rr_seq[i] == 8'h80) checkOutput("rr_data7", 64'(data), 64'hB777_7777);
         else checkOutput("rr_bubble_valid", 64'(valid), 64'h0);
      end

      // Four-beat burst from requester 3 with ready toggling; requester 5 waits
      setWord(3, burst[0]);
      setWord(5, 32'h5555_5555);
      applyStimulus(8'h28, 8'h00, 1'b0);
      nextCycle();
      checkOutput("burst_gnt", 64'(gnt), 64'h08);
      b = 0;
      for (int i = 0; i < 7; i++) begin
         setWord(3, burst[b]);
         applyStimulus(8'h28, (b == 3) ? 8'h08 : 8'h00, (i % 2) == 0);
         #1;
         checkOutput("burst_data", 64'(data), 64'(burst[b]));
         checkOutput("burst_sel", 64'(sel), 64'h3);
         nextCycle();
         if (ready) b++;
         if (b < 4) checkOutput("burst_cnt", 64'(beat_cnt), 64'(b));
      end
      checkOutput("burst_release_gnt", 64'(gnt), 64'h00);
      checkOutput("burst_release_cnt", 64'(beat_cnt), 64'h0);
      applyStimulus(8'h20, 8'h00, 1'b0);
      nextCycle();
      checkOutput("next_owner_gnt", 64'(gnt), 64'h20);
      checkOutput("next_owner_sel", 64'(sel), 64'h5);
      applyStimulus(8'h20, 8'h20, 1'b1);
      nextCycle();
      checkOutput("owner5_release", 64'(gnt), 64'h00);

      // Requester 2 takes one beat, then goes quiet until the forced release
      applyStimulus(8'h04, 8'h00, 1'b1);
      nextCycle();
      checkOutput("tmo_gnt", 64'(gnt), 64'h04);
      nextCycle();
      checkOutput("tmo_cnt", 64'(beat_cnt), 64'h1);
      applyStimulus(8'h00, 8'h00, 1'b1);
      for (int i = 1; i <= TIMEOUT; i++) begin
         nextCycle();
         checkOutput("tmo_wait_gnt", 64'(gnt), 64'h04);
         checkOutput("tmo_wait_pulse", 64'(timeout), 64'h0);
      end
      nextCycle();
      checkOutput("tmo_pulse", 64'(timeout), 64'h1);
      checkOutput("tmo_gnt_clear", 64'(gnt), 64'h00);
      checkOutput("tmo_cnt_clear", 64'(beat_cnt), 64'h0);
      applyStimulus(8'h14, 8'h00, 1'b0);
      nextCycle();
      checkOutput("tmo_fair_gnt", 64'(gnt), 64'h10);
      checkOutput("tmo_pulse_once", 64'(timeout), 64'h0);
      applyStimulus(8'h14, 8'h10, 1'b1);
      nextCycle();
      checkOutput("owner4_release", 64'(gnt), 64'h00);

      // Requester 6 finishes just before the timeout, then exactly at it
      applyStimulus(8'h40, 8'h00, 1'b0);
      nextCycle();
      checkOutput("r6_gnt", 64'(gnt), 64'h40);
      applyStimulus(8'h00, 8'h00, 1'b1);
      repeat (TIMEOUT - 1) nextCycle();
      applyStimulus(8'h40, 8'h40, 1'b1);
      #1;
      checkOutput("r6_valid", 64'(valid), 64'h1);
      nextCycle();
      checkOutput("r6_release_gnt", 64'(gnt), 64'h00);
      checkOutput("r6_no_pulse", 64'(timeout), 64'h0);
      applyStimulus(8'h40, 8'h00, 1'b0);
      nextCycle();
      checkOutput("r6_regnt", 64'(gnt), 64'h40);
      applyStimulus(8'h00, 8'h00, 1'b1);
      repeat (TIMEOUT) nextCycle();
      checkOutput("r6_held", 64'(gnt), 64'h40);
      applyStimulus(8'h40, 8'h40, 1'b1);
      nextCycle();
      checkOutput("r6_last_wins_gnt", 64'(gnt), 64'h00);
      checkOutput("r6_last_wins_pulse", 64'(timeout), 64'h0);

      // Reset asserted between edges in the middle of a burst from requester 1
      applyStimulus(8'h02, 8'h00, 1'b1);
      nextCycle();
      checkOutput("r1_gnt", 64'(gnt), 64'h02);
      nextCycle();
      nextCycle();
      checkOutput("r1_cnt", 64'(beat_cnt), 64'h2);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_gnt", 64'(gnt), 64'h00);
      checkOutput("rst_sel", 64'(sel), 64'h0);
      checkOutput("rst_valid", 64'(valid), 64'h0);
      checkOutput("rst_data", 64'(data), 64'h0);
      checkOutput("rst_cnt", 64'(beat_cnt), 64'h0);
      checkOutput("rst_timeout", 64'(timeout), 64'h0);
      #2 rst_n = 1'b1;
      applyStimulus(8'h03, 8'h00, 1'b0);
      nextCycle();
      checkOutput("rst_tie_gnt", 64'(gnt), 64'h01);
      applyStimulus(8'h03, 8'h01, 1'b1);
      nextCycle();

      // Random traffic with sticky requests so owners sometimes stay quiet long enough to time out
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 7) == 0) sticky[k] = ~sticky[k];
            setWord(k, $urandom());
         end
         applyStimulus(sticky, 8'($urandom()) & 8'($urandom()), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         nextCycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
